// File: rtl/vector_issue_sequencer_if.sv
// Request/issue bus of the vector issue sequencer.
// master = instruction source and downstream stage; slave = the sequencer.
interface vector_issue_sequencer_if #(
  parameter int LANES = 4,
  parameter int VL_W  = 5,
  parameter int RA_W  = 5
) ();
  // Handshakes: an instruction transfers on a rising edge where req_valid & req_ready.
  // The source holds req_valid and its fields steady until that edge. A beat is
  // consumed on a rising edge where issue_valid is high; stall suppresses
  // issue_valid and freezes the beat in place.
  logic             req_valid;
  logic             req_ready;
  logic [RA_W-1:0]  req_vs1;
  logic [RA_W-1:0]  req_vs2;
  logic [RA_W-1:0]  req_vd;
  logic [VL_W-1:0]  req_vl;
  logic             req_multi;
  logic             req_fix_vd;
  logic             req_widen;
  logic             stall;
  logic             issue_valid;
  logic             issue_last;
  logic [RA_W-1:0]  vs1_addr;
  logic [RA_W-1:0]  vs2_addr;
  logic [RA_W-1:0]  vd_addr;
  logic [LANES-1:0] elem_mask;
  logic             done;

  modport master (
    output req_valid, req_vs1, req_vs2, req_vd, req_vl,
           req_multi, req_fix_vd, req_widen, stall,
    input  req_ready, issue_valid, issue_last, vs1_addr, vs2_addr,
           vd_addr, elem_mask, done
  );

  modport slave (
    input  req_valid, req_vs1, req_vs2, req_vd, req_vl,
           req_multi, req_fix_vd, req_widen, stall,
    output req_ready, issue_valid, issue_last, vs1_addr, vs2_addr,
           vd_addr, elem_mask, done
  );
endinterface

// File: rtl/vector_issue_sequencer.sv
// Splits an accepted vector instruction into LANES-wide beats with per-beat register addresses.
// Define VEC_SEQ_SKID_EN for a one-entry pending buffer giving bubble-free back-to-back issue.
module vector_issue_sequencer #(
  parameter int LANES = 4,
  parameter int VL_W  = 5,
  parameter int RA_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  vector_issue_sequencer_if.slave   bus,
  output logic [0:0]                o_dbg_state
);
  localparam int LG = $clog2(LANES);

  typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_t;

  typedef struct packed {
    logic [RA_W-1:0] vs1;
    logic [RA_W-1:0] vs2;
    logic [RA_W-1:0] vd;
    logic [VL_W-1:0] vl;
    logic            multi;
    logic            fix_vd;
    logic            widen;
  } instr_t;

  state_t           r_state;
  logic             r_active;
  logic             r_last;
  logic             r_zero_done;
  logic [RA_W-1:0]  r_vs1_addr;
  logic [RA_W-1:0]  r_vs2_addr;
  logic [RA_W-1:0]  r_vd_addr;
  logic [RA_W-1:0]  r_vd_step;
  logic [LANES-1:0] r_mask;
  logic [LANES-1:0] r_last_mask;
  logic [VL_W-1:0]  r_left;

  instr_t           w_in;
  instr_t           w_src;
  logic             w_ready;
  logic             w_acc;
  logic             w_fin;
  logic             w_adv;
  logic             w_load;
  logic             w_to_idle;
  logic             w_has;
  logic             w_pend_full;
  logic [VL_W-1:0]  w_nb;
  logic [LG-1:0]    w_rem;
  logic [LANES-1:0] w_lmask;
  logic [RA_W-1:0]  w_step;

  assign w_in = {bus.req_vs1, bus.req_vs2, bus.req_vd, bus.req_vl,
                 bus.req_multi, bus.req_fix_vd, bus.req_widen};

`ifdef VEC_SEQ_SKID_EN
  instr_t r_pend;
  logic   r_pend_full;
  assign w_pend_full = r_pend_full;
  assign w_ready     = !r_pend_full;
  assign w_src       = r_pend_full ? r_pend : w_in;
`else
  assign w_pend_full = 1'b0;
  assign w_ready     = (r_state == IDLE);
  assign w_src       = w_in;
`endif

  assign w_acc = bus.req_valid & w_ready;
  // A zero-length op finishes through r_zero_done without ever issuing a beat.
  assign w_fin = (r_active & r_last & !bus.stall) | r_zero_done;
  assign w_adv = r_active & !r_last & !bus.stall;

  assign w_load    = ((r_state == IDLE) & w_acc) |
                     ((r_state == EXEC) & w_fin & (w_pend_full | w_acc));
  assign w_to_idle = (r_state == EXEC) & w_fin & !(w_pend_full | w_acc);

  always_comb begin
    w_rem   = w_src.vl[LG-1:0];
    w_nb    = w_src.multi ? (w_src.vl >> LG) + VL_W'(w_rem != '0) : VL_W'(1);
    w_has   = (w_nb != '0);
    w_lmask = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lmask[i] = (w_rem == '0) || (i < int'(w_rem));
    end
    if (!w_src.multi) w_lmask = LANES'(1);
    w_step  = w_src.fix_vd ? '0 : (w_src.widen ? RA_W'(2) : RA_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_active    <= 1'b0;
      r_last      <= 1'b0;
      r_zero_done <= 1'b0;
      r_vs1_addr  <= '0;
      r_vs2_addr  <= '0;
      r_vd_addr   <= '0;
      r_vd_step   <= '0;
      r_mask      <= '0;
      r_last_mask <= '0;
      r_left      <= '0;
`ifdef VEC_SEQ_SKID_EN
      r_pend      <= '0;
      r_pend_full <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_state     <= EXEC;
        r_active    <= w_has;
        r_zero_done <= !w_has;
        r_last      <= (w_nb == VL_W'(1));
        r_left      <= w_has ? w_nb - VL_W'(1) : '0;
        r_vs1_addr  <= w_has ? w_src.vs1 : '0;
        r_vs2_addr  <= w_has ? w_src.vs2 : '0;
        r_vd_addr   <= w_has ? w_src.vd : '0;
        r_mask      <= !w_has ? '0 : ((w_nb == VL_W'(1)) ? w_lmask : '1);
        r_last_mask <= w_lmask;
        r_vd_step   <= w_step;
      end else if (w_to_idle) begin
        r_state     <= IDLE;
        r_active    <= 1'b0;
        r_last      <= 1'b0;
        r_zero_done <= 1'b0;
        r_vs1_addr  <= '0;
        r_vs2_addr  <= '0;
        r_vd_addr   <= '0;
        r_mask      <= '0;
        r_left      <= '0;
      end else if (w_adv) begin
        r_vs1_addr  <= r_vs1_addr + RA_W'(1);
        r_vs2_addr  <= r_vs2_addr + RA_W'(1);
        r_vd_addr   <= r_vd_addr + r_vd_step;
        r_left      <= r_left - VL_W'(1);
        r_last      <= (r_left == VL_W'(1));
        r_mask      <= (r_left == VL_W'(1)) ? r_last_mask : '1;
      end
`ifdef VEC_SEQ_SKID_EN
      // The pending entry drains at every finish; new work parks only mid-instruction.
      if ((r_state == EXEC) && w_fin) begin
        r_pend_full <= 1'b0;
      end else if ((r_state == EXEC) && w_acc) begin
        r_pend      <= w_in;
        r_pend_full <= 1'b1;
      end
`endif
    end
  end

  assign bus.req_ready   = w_ready & !reset;
  assign bus.issue_valid = r_active & !bus.stall & !reset;
  assign bus.issue_last  = r_active & r_last & !bus.stall & !reset;
  assign bus.done        = w_fin & !reset;
  assign bus.vs1_addr    = reset ? '0 : r_vs1_addr;
  assign bus.vs2_addr    = reset ? '0 : r_vs2_addr;
  assign bus.vd_addr     = reset ? '0 : r_vd_addr;
  assign bus.elem_mask   = reset ? '0 : r_mask;
  assign o_dbg_state     = r_state;
endmodule
